// File: rtl/lsu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lsu_instr_sequencer
// Brief    : Issues a small preloaded instruction program over a valid/ready
//            handshake. After each load or store, issue is held until the
//            matching memory response arrives or the wait times out.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_instr_sequencer #(
  parameter int DEPTH   = 4,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [31:0]   prog_data_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  output logic [31:0]   instr_o,
  output logic          instr_valid_o,
  input  logic          instr_ready_i,
  input  logic          load_mem_resp_i,
  input  logic          store_mem_resp_i,
  output logic [AW:0]   pc_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_MEM = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [6:0]  c_op_load   = 7'b0000011;
  localparam logic [6:0]  c_op_store  = 7'b0100011;
  localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_pc_one    = (AW+1)'(1);
  // Counter starts at 0 on the first wait cycle, so expiry is on TIMEOUT-1.
  localparam logic [7:0]  c_wait_last = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [AW:0] r_pc;
  logic [AW:0] r_len;
  logic [7:0]  r_wait_cnt;
  logic        r_wait_load;
  logic        r_timeout;
  logic [31:0] r_buf [DEPTH];

  logic        w_can_load;
  logic [31:0] w_instr;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic [AW:0] w_pc_inc;
  logic [AW:0] w_len_clamped;
  logic        w_resp_match;

  assign w_can_load    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_instr       = r_buf[r_pc[AW-1:0]];
  assign w_is_load     = (w_instr[6:0] == c_op_load);
  assign w_is_store    = (w_instr[6:0] == c_op_store);
  assign w_is_mem      = w_is_load || w_is_store;
  assign w_pc_inc      = r_pc + c_pc_one;
  assign w_len_clamped = (prog_len_i > c_depth) ? c_depth : prog_len_i;
  assign w_resp_match  = r_wait_load ? load_mem_resp_i : store_mem_resp_i;

  // Program buffer: written only while no run is in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_can_load && prog_we_i) begin
      r_buf[prog_addr_i] <= prog_data_i;
    end
  end

  // Sequencer FSM: launch, issue, wait for memory response, finish.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_len       <= '0;
      r_wait_cnt  <= '0;
      r_wait_load <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_len     <= w_len_clamped;
            r_pc      <= '0;
            r_timeout <= 1'b0;
            r_state   <= (w_len_clamped != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          if (instr_ready_i) begin
            r_pc <= w_pc_inc;
            if (w_is_mem) begin
              r_wait_load <= w_is_load;
              r_wait_cnt  <= '0;
              r_state     <= S_WAIT_MEM;
            end else if (w_pc_inc == r_len) begin
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT_MEM: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          // A matching response takes priority over expiry in the same cycle.
          if (w_resp_match) begin
            r_state <= (r_pc == r_len) ? S_DONE : S_ISSUE;
          end else if (r_wait_cnt == c_wait_last) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_o       = w_instr;
  assign instr_valid_o = (r_state == S_ISSUE);
  assign busy_o        = (r_state == S_ISSUE) || (r_state == S_WAIT_MEM);
  assign done_o        = (r_state == S_DONE);
  assign pc_o          = r_pc;
  assign timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_lsu_instr_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lsu_instr_sequencer
// Brief    : Directed self-checking bench for lsu_instr_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_instr_sequencer;

  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int TIMEOUT = 15;

  localparam logic [31:0] c_addi = 32'h00000093;
  localparam logic [31:0] c_lw   = 32'h00002083;
  localparam logic [31:0] c_sw   = 32'h00102023;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          load_resp = 1'b0;
  logic          store_resp = 1'b0;
  logic [AW:0]   pc;
  logic          busy;
  logic          done;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  lsu_instr_sequencer #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .prog_we_i        (prog_we),
    .prog_addr_i      (prog_addr),
    .prog_data_i      (prog_data),
    .prog_len_i       (prog_len),
    .start_i          (start),
    .instr_o          (instr),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .load_mem_resp_i  (load_resp),
    .store_mem_resp_i (store_resp),
    .pc_o             (pc),
    .busy_o           (busy),
    .done_o           (done),
    .timeout_o        (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic prog_write(input logic [AW-1:0] addr, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic start_run(input logic [AW:0] len);
    start    = 1'b1;
    prog_len = len;
    step();
    start    = 1'b0;
  endtask

  initial begin
    int exp_v [12] = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    int hs;
    int vc;

    // Reset state
    #1 rst = 1'b1;
    #11;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_instr", instr, 32'd0);
    rst = 1'b0;
    step();

    // ALU stream: four addi, ready high
    for (int i = 0; i < 4; i++) prog_write(AW'(i), c_addi);
    instr_ready = 1'b1;
    start_run(3'd4);
    for (int i = 0; i < 4; i++) begin
      check("alu_valid", 32'(instr_valid), 32'd1);
      check("alu_pc", 32'(pc), 32'(i));
      check("alu_instr", instr, c_addi);
      step();
    end
    check("alu_done", 32'(done), 32'd1);
    check("alu_valid_end", 32'(instr_valid), 32'd0);
    check("alu_pc_end", 32'(pc), 32'd4);
    check("alu_busy_end", 32'(busy), 32'd0);

    // LW/SW/LW/ADDI with delayed responses
    prog_write(2'd0, c_lw);
    prog_write(2'd1, c_sw);
    prog_write(2'd2, c_lw);
    prog_write(2'd3, c_addi);
    start_run(3'd4);
    hs = 0;
    for (int i = 1; i <= 12; i++) begin
      load_resp  = (i == 4) || (i == 11);
      store_resp = (i == 7);
      check("mem_valid", 32'(instr_valid), 32'(exp_v[i-1]));
      if (instr_valid && instr_ready) hs++;
      step();
    end
    load_resp  = 1'b0;
    store_resp = 1'b0;
    check("mem_done", 32'(done), 32'd1);
    check("mem_timeout", 32'(timeout), 32'd0);
    check("mem_handshakes", 32'(hs), 32'd4);

    // Wrong-kind response while a store waits
    prog_write(2'd0, c_sw);
    prog_write(2'd1, 32'h00100093);
    start_run(3'd2);
    check("wk_first", instr, c_sw);
    step();
    check("wk_wait_valid", 32'(instr_valid), 32'd0);
    step();
    load_resp = 1'b1;
    step();
    load_resp = 1'b0;
    check("wk_ignored", 32'(instr_valid), 32'd0);
    check("wk_busy", 32'(busy), 32'd1);
    step();
    store_resp = 1'b1;
    step();
    store_resp = 1'b0;
    check("wk_resume_valid", 32'(instr_valid), 32'd1);
    check("wk_resume_instr", instr, 32'h00100093);
    step();
    check("wk_done", 32'(done), 32'd1);

    // Timeout on a load with no response
    prog_write(2'd0, c_lw);
    start_run(3'd1);
    step();
    repeat (14) step();
    check("to_not_yet", 32'(done), 32'd0);
    check("to_busy", 32'(busy), 32'd1);
    step();
    check("to_done", 32'(done), 32'd1);
    check("to_flag", 32'(timeout), 32'd1);

    // Zero-length run: straight to DONE, clears timeout
    start_run(3'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_valid", 32'(instr_valid), 32'd0);
    check("len0_timeout", 32'(timeout), 32'd0);
    check("len0_pc", 32'(pc), 32'd0);

    // Response on the expiry cycle wins
    start_run(3'd1);
    step();
    repeat (14) step();
    load_resp = 1'b1;
    step();
    load_resp = 1'b0;
    check("edge_done", 32'(done), 32'd1);
    check("edge_timeout", 32'(timeout), 32'd0);

    // Backpressure: ready low for 5 cycles
    for (int i = 0; i < 4; i++) prog_write(AW'(i), c_addi | (32'(i + 1) << 20));
    start_run(3'd4);
    check("bp_pc0", 32'(pc), 32'd0);
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_pc", 32'(pc), 32'd1);
      check("bp_instr", instr, 32'h00200093);
      step();
    end
    instr_ready = 1'b1;
    check("bp_hold_end", 32'(pc), 32'd1);
    step();
    check("bp_pc2", 32'(pc), 32'd2);
    step();
    check("bp_pc3", 32'(pc), 32'd3);
    step();
    check("bp_done", 32'(done), 32'd1);
    check("bp_pc4", 32'(pc), 32'd4);

    // Length clamp: 7 requested, DEPTH entries issued
    start_run(3'd7);
    vc = 0;
    repeat (6) begin
      if (instr_valid) vc++;
      step();
    end
    check("clamp_issues", 32'(vc), 32'd4);
    check("clamp_pc", 32'(pc), 32'd4);
    check("clamp_done", 32'(done), 32'd1);

    // Write and start in the same cycle: run sees the new word
    prog_we   = 1'b1;
    prog_addr = 2'd0;
    prog_data = 32'h00500093;
    start     = 1'b1;
    prog_len  = 3'd1;
    step();
    prog_we = 1'b0;
    start   = 1'b0;
    check("ws_instr", instr, 32'h00500093);
    check("ws_valid", 32'(instr_valid), 32'd1);
    step();
    check("ws_done", 32'(done), 32'd1);

    // Asynchronous reset mid-ISSUE
    start_run(3'd4);
    step();
    instr_ready = 1'b0;
    check("ar_pre_pc", 32'(pc), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(instr_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_pc", 32'(pc), 32'd0);
    #3 rst = 1'b0;
    step();
    check("ar_idle_busy", 32'(busy), 32'd0);
    check("ar_idle_done", 32'(done), 32'd0);
    check("ar_idle_valid", 32'(instr_valid), 32'd0);
    check("ar_buf_clear", instr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
